// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: double-buffered BCD value,
// per-digit guard gap, shared external decoder, registered segment/digit bus.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [3:0]              dec_data,
  input  logic [6:0]              dec_segments,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_DASH = 7'b000_0001;

  typedef enum logic {GAP, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_buf_q, disp_buf_d;
  logic [4*NUM_DIGITS-1:0] pend_buf_q, pend_buf_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;

  logic [3:0]              nib;
  logic                    blank;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   idx_onehot;
  logic                    last_idx;

  // Decoder input depends only on idx and the display buffer, so it settles during GAP.
  always_comb begin
    nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) nib = disp_buf_q[4*i +: 4];
    end
  end

  assign dec_data = nib;

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    blank    = 1'b0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (disp_buf_q[4*i +: 4] == 4'd0);
      if (blank_lz && zero_run && (idx_q == IW'(i))) blank = 1'b1;
    end
  end

  always_comb begin
    idx_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      idx_onehot[i] = (idx_q == IW'(i));
    end
  end

  assign last_idx = (idx_q == IW'(NUM_DIGITS - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    disp_buf_d   = disp_buf_q;
    pend_buf_d   = pend_buf_q;
    pending_d    = pending_q;
    seg_d        = seg_q;
    digit_en_d   = digit_en_q;
    frame_done_d = 1'b0;

    if (!en) begin
      // Parked: restart at digit 0, loads go straight to the display buffer.
      state_d    = GAP;
      cnt_d      = '0;
      idx_d      = '0;
      seg_d      = '0;
      digit_en_d = '0;
      pending_d  = 1'b0;
      if (load)           disp_buf_d = value;
      else if (pending_q) disp_buf_d = pend_buf_q;
    end else begin
      if (load) begin
        pend_buf_d = value;
        pending_d  = 1'b1;
      end
      case (state_q)
        GAP: begin
          if (cnt_q == CW'(GUARD - 1)) begin
            state_d    = SHOW;
            cnt_d      = '0;
            digit_en_d = idx_onehot;
            if (blank)            seg_d = '0;
            else if (nib > 4'd9)  seg_d = SEG_DASH;
            else                  seg_d = dec_segments;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SHOW: begin
          if (cnt_q == CW'(DWELL - 1)) begin
            state_d    = GAP;
            cnt_d      = '0;
            seg_d      = '0;
            digit_en_d = '0;
            idx_d      = last_idx ? '0 : idx_q + IW'(1);
            if (last_idx) begin
              // Frame boundary: a same-cycle load bypasses the pending buffer.
              frame_done_d = 1'b1;
              pending_d    = 1'b0;
              if (load)           disp_buf_d = value;
              else if (pending_q) disp_buf_d = pend_buf_q;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = GAP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= GAP;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_buf_q   <= '0;
      pend_buf_q   <= '0;
      pending_q    <= 1'b0;
      seg_q        <= '0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_buf_q   <= disp_buf_d;
      pend_buf_q   <= pend_buf_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign digit_en   = digit_en_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: position-in-frame reference model plus
// directed scenarios and a randomized run.
module tb_sevenseg_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int GD = 1;
  localparam int SL = GD + DW;
  localparam int F  = ND * SL;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dec_data;
  logic [6:0]  dec_segments;
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  logic        pending;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the frame plus buffer contents.
  int          pos;
  logic [15:0] m_disp, m_pend;
  logic        m_pv, m_fd;
  logic [6:0]  m_seg;
  logic [3:0]  m_en;

  sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .DWELL(DW), .GUARD(GD)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .value(value),
    .blank_lz(blank_lz), .dec_data(dec_data), .dec_segments(dec_segments),
    .seg(seg), .digit_en(digit_en), .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0: return 7'b111_1110;
      4'd1: return 7'b011_0000;
      4'd2: return 7'b110_1101;
      4'd3: return 7'b111_1001;
      4'd4: return 7'b011_0011;
      4'd5: return 7'b101_1011;
      4'd6: return 7'b101_1111;
      4'd7: return 7'b111_0000;
      4'd8: return 7'b111_1111;
      4'd9: return 7'b111_0011;
      default: return 7'b100_0111;
    endcase
  endfunction

  assign dec_segments = dec7(dec_data);

  function automatic logic [6:0] exp_seg_of(input logic [15:0] d, input int slot, input logic blz);
    logic [3:0] n;
    n = d[4*slot +: 4];
    if (blz && slot > 0 && (d >> (4*slot)) == 16'd0) return 7'd0;
    if (n > 4'd9) return 7'b000_0001;
    return dec7(n);
  endfunction

  function automatic logic [3:0] exp_dec(input logic [15:0] d, input int p);
    return d[4*(p/SL) +: 4];
  endfunction

  task automatic model_reset();
    pos = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0; m_fd = 1'b0; m_seg = '0; m_en = '0;
  endtask

  task automatic model_step();
    int slot, s;
    if (!en) begin
      pos = 0; m_seg = '0; m_en = '0; m_fd = 1'b0;
      if (load) m_disp = value;
      else if (m_pv) m_disp = m_pend;
      m_pv = 1'b0;
    end else begin
      m_fd = (pos == F - 1);
      if (m_fd) begin
        m_disp = load ? value : (m_pv ? m_pend : m_disp);
        m_pv = 1'b0;
        if (load) m_pend = value;
      end else if (load) begin
        m_pend = value; m_pv = 1'b1;
      end
      pos  = (pos + 1) % F;
      slot = pos / SL;
      s    = pos % SL;
      if (s < GD) begin
        m_seg = '0; m_en = '0;
      end else if (s == GD) begin
        m_en  = 4'(1 << slot);
        m_seg = exp_seg_of(m_disp, slot, blank_lz);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic goto_pos(input int p);
    for (int n = 0; n < F && pos != p; n++) tick();
  endtask

  task automatic test_reset();
    logic [16:0] got, expv;
    int lit[ND];
    int fd_cnt;
    fd_cnt = 0;
    for (int k = 0; k < ND; k++) lit[k] = 0;
    reset_n = 1'b0; en = 1'b1; blank_lz = 1'b0;
    repeat (2) tick();
    checks++;
    if ({seg, digit_en, pending, frame_done, dec_data} !== 17'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {seg, digit_en, pending, frame_done, dec_data});
    end
    #3 reset_n = 1'b1;
    for (int c = 0; c < 45; c++) begin
      got  = {seg, digit_en, pending, frame_done, dec_data};
      expv = {m_seg, m_en, m_pv, m_fd, exp_dec(m_disp, pos)};
      checks++;
      if (got !== expv) begin errors++; $display("FAIL scan_zero c=%0d got=%h exp=%h", c, got, expv); end
      if (digit_en !== 4'd0) begin
        checks++;
        if (seg !== 7'b111_1110) begin errors++; $display("FAIL zero_seg c=%0d got=%b exp=1111110", c, seg); end
      end
      for (int k = 0; k < ND; k++) if (digit_en === 4'(1 << k)) lit[k]++;
      if (frame_done === 1'b1) fd_cnt++;
      tick();
    end
    checks++;
    if (fd_cnt != 2) begin errors++; $display("FAIL frame_done_count got=%0d exp=2", fd_cnt); end
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (lit[k] != ((k == 0) ? 12 : 8)) begin
        errors++; $display("FAIL dwell_count digit=%0d got=%0d exp=%0d", k, lit[k], (k == 0) ? 12 : 8);
      end
    end
  endtask

  task automatic test_load();
    logic [16:0] got, expv;
    logic [6:0] tbl [ND] = '{7'b011_0011, 7'b111_1001, 7'b110_1101, 7'b011_0000};
    goto_pos(7);
    value = 16'h1234; load = 1'b1; tick(); load = 1'b0;
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL load_pending got=%b exp=1", pending); end
    for (int n = 0; n < 2*F && frame_done !== 1'b1; n++) begin
      checks++;
      if (digit_en !== 4'd0 && seg !== 7'b111_1110) begin
        errors++; $display("FAIL frame_unchanged got=%b exp=1111110", seg);
      end
      tick();
    end
    checks++;
    if (frame_done !== 1'b1 || pending !== 1'b0) begin
      errors++; $display("FAIL load_boundary got fd=%b pend=%b exp fd=1 pend=0", frame_done, pending);
    end
    for (int c = 0; c < F; c++) begin
      got  = {seg, digit_en, pending, frame_done, dec_data};
      expv = {m_seg, m_en, m_pv, m_fd, exp_dec(m_disp, pos)};
      checks++;
      if (got !== expv) begin errors++; $display("FAIL load_frame c=%0d got=%h exp=%h", c, got, expv); end
      for (int k = 0; k < ND; k++) if (digit_en === 4'(1 << k)) begin
        checks++;
        if (seg !== tbl[k]) begin errors++; $display("FAIL load_digit%0d got=%b exp=%b", k, seg, tbl[k]); end
      end
      tick();
    end
  endtask

  task automatic test_blank();
    logic [16:0] got, expv;
    logic [6:0] tbl [2][ND] = '{'{7'b111_1110, 7'b101_1011, 7'd0, 7'd0},
                                '{7'b111_1110, 7'd0, 7'd0, 7'd0}};
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    int lit[ND];
    blank_lz = 1'b1;
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < ND; k++) lit[k] = 0;
      goto_pos(3);
      value = vals[v]; load = 1'b1; tick(); load = 1'b0;
      for (int n = 0; n < 2*F && frame_done !== 1'b1; n++) tick();
      checks++;
      if (frame_done !== 1'b1) begin errors++; $display("FAIL blank_boundary got=%b exp=1", frame_done); end
      for (int c = 0; c < F; c++) begin
        got  = {seg, digit_en, pending, frame_done, dec_data};
        expv = {m_seg, m_en, m_pv, m_fd, exp_dec(m_disp, pos)};
        checks++;
        if (got !== expv) begin errors++; $display("FAIL blank_frame v=%0d c=%0d got=%h exp=%h", v, c, got, expv); end
        for (int k = 0; k < ND; k++) if (digit_en === 4'(1 << k)) begin
          lit[k]++;
          checks++;
          if (seg !== tbl[v][k]) begin errors++; $display("FAIL blank_digit%0d v=%0d got=%b exp=%b", k, v, seg, tbl[v][k]); end
        end
        tick();
      end
      for (int k = 0; k < ND; k++) begin
        checks++;
        if (lit[k] != DW) begin errors++; $display("FAIL blank_slot digit=%0d got=%0d exp=%0d", k, lit[k], DW); end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [16:0] got, expv;
    logic [6:0] tbl [2][ND] = '{'{7'b101_1111, 7'b111_0000, 7'b111_1111, 7'b111_0011},
                                '{7'b111_1110, 7'b000_0001, 7'b111_1110, 7'b111_1110}};
    goto_pos(3);
    value = 16'h1111; load = 1'b1; tick(); load = 1'b0;
    goto_pos(10);
    value = 16'h9876; load = 1'b1; tick(); load = 1'b0;
    for (int v = 0; v < 2; v++) begin
      if (v == 1) begin
        goto_pos(F - 1);
        value = 16'h00A0; load = 1'b1; tick(); load = 1'b0;
      end else begin
        for (int n = 0; n < 2*F && frame_done !== 1'b1; n++) tick();
      end
      checks++;
      if (frame_done !== 1'b1 || pending !== 1'b0) begin
        errors++; $display("FAIL b2b_boundary v=%0d got fd=%b pend=%b exp fd=1 pend=0", v, frame_done, pending);
      end
      for (int c = 0; c < F; c++) begin
        got  = {seg, digit_en, pending, frame_done, dec_data};
        expv = {m_seg, m_en, m_pv, m_fd, exp_dec(m_disp, pos)};
        checks++;
        if (got !== expv) begin errors++; $display("FAIL b2b_frame v=%0d c=%0d got=%h exp=%h", v, c, got, expv); end
        for (int k = 0; k < ND; k++) if (digit_en === 4'(1 << k)) begin
          checks++;
          if (seg !== tbl[v][k]) begin errors++; $display("FAIL b2b_digit%0d v=%0d got=%b exp=%b", k, v, seg, tbl[v][k]); end
        end
        tick();
      end
    end
  endtask

  task automatic test_async_reset();
    logic [16:0] got, expv;
    goto_pos(9);
    value = 16'h5555; load = 1'b1; tick(); load = 1'b0;
    goto_pos(13);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({seg, digit_en, pending} !== 12'd0) begin
      errors++; $display("FAIL async_reset got seg=%b en=%b pend=%b exp all 0", seg, digit_en, pending);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    for (int c = 0; c < F; c++) begin
      got  = {seg, digit_en, pending, frame_done, dec_data};
      expv = {m_seg, m_en, m_pv, m_fd, exp_dec(m_disp, pos)};
      checks++;
      if (got !== expv) begin errors++; $display("FAIL reset_frame c=%0d got=%h exp=%h", c, got, expv); end
      if (digit_en !== 4'd0) begin
        checks++;
        if (seg !== 7'b111_1110) begin errors++; $display("FAIL reset_seg c=%0d got=%b exp=1111110", c, seg); end
      end
      tick();
    end
  endtask

  task automatic test_enable();
    logic [16:0] got, expv;
    logic [6:0] tbl [ND] = '{7'b011_0000, 7'b110_1101, 7'b111_1001, 7'b011_0011};
    goto_pos(2);
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({seg, digit_en, frame_done} !== 12'd0) begin
        errors++; $display("FAIL en_off c=%0d got seg=%b en=%b fd=%b exp all 0", c, seg, digit_en, frame_done);
      end
    end
    value = 16'h4321; load = 1'b1; tick(); load = 1'b0;
    checks++;
    if (pending !== 1'b0 || dec_data !== 4'h1) begin
      errors++; $display("FAIL en_off_load got pend=%b dec=%h exp pend=0 dec=1", pending, dec_data);
    end
    en = 1'b1;
    for (int c = 0; c < F; c++) begin
      got  = {seg, digit_en, pending, frame_done, dec_data};
      expv = {m_seg, m_en, m_pv, m_fd, exp_dec(m_disp, pos)};
      checks++;
      if (got !== expv) begin errors++; $display("FAIL en_frame c=%0d got=%h exp=%h", c, got, expv); end
      for (int k = 0; k < ND; k++) if (digit_en === 4'(1 << k)) begin
        checks++;
        if (seg !== tbl[k]) begin errors++; $display("FAIL en_digit%0d got=%b exp=%b", k, seg, tbl[k]); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [16:0] got, expv;
    logic [15:0] v;
    for (int c = 0; c < 800; c++) begin
      got  = {seg, digit_en, pending, frame_done, dec_data};
      expv = {m_seg, m_en, m_pv, m_fd, exp_dec(m_disp, pos)};
      checks++;
      if (got !== expv) begin errors++; $display("FAIL random c=%0d got=%h exp=%h", c, got, expv); end
      checks++;
      if ($countones(digit_en) > 1) begin errors++; $display("FAIL onehot c=%0d got=%b exp<=1 bit", c, digit_en); end
      for (int k = 0; k < ND; k++) v[4*k +: 4] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
      value = v;
      load  = ($urandom_range(7) == 0);
      if ($urandom_range(31) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(63) == 0) en = ~en;
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_blank();
    test_back_to_back();
    test_async_reset();
    test_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
